pico_pc_seq: RTL and testbench

//  Program-counter sequencer for the PicoMIPS core; sits directly upstream of

---
 rtl/pico_pc_seq_pkg.sv | 15 +
 rtl/pico_pc_seq_if.sv | 27 ++
 rtl/pico_ret_stack.sv | 53 +++++
 rtl/pico_pc_seq.sv | 102 ++++++++++
 tb/tb_pico_pc_seq.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/pico_pc_seq_pkg.sv
// Shared types and sizing for the PicoMIPS program-counter sequencer.
// Holds the decoder PC modes, the run-control states and the sign-extension helper.
package pico_pc_seq_pkg;
    localparam int A     = 4;
    localparam int W_IMM = 8;
    localparam int S     = 4;

    typedef enum logic [1:0] {INCREMENT, RELATIVE, SUBROUTINE, RETURN} mode_pc_t;
    typedef enum logic [1:0] {RUN, WAIT, HALT} pc_state_t;

    // Branch offsets are summed at W_IMM+1 bits so the wrap is taken from the true sum
    function automatic logic [W_IMM:0] sext_imm(input logic [W_IMM-1:0] v);
        return {v[W_IMM-1], v};
    endfunction
endpackage

// File: rtl/pico_pc_seq_if.sv
// Decoder-facing bundle of the PC sequencer: mode/immediate/run-control in,
// fetch address and status out.
interface pico_pc_seq_if;
    import pico_pc_seq_pkg::*;

    mode_pc_t         mode;
    logic [W_IMM-1:0] imm;
    logic             branch_take;
    logic             halt_req;
    logic             wfi_req;
    logic             irq;
    logic [A-1:0]     pc;
    logic             running;
    logic             waiting;
    logic             stk_ovf;
    logic             stk_unf;

    modport master (
        output mode, imm, branch_take, halt_req, wfi_req, irq,
        input  pc, running, waiting, stk_ovf, stk_unf
    );

    modport slave (
        input  mode, imm, branch_take, halt_req, wfi_req, irq,
        output pc, running, waiting, stk_ovf, stk_unf
    );
endinterface

// File: rtl/pico_ret_stack.sv
// Hardware return-address LIFO. Top-of-stack is read straight from the
// registered storage; push/pop are ignored when full/empty respectively.
module pico_ret_stack #(
    parameter int A = 4,
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic         push,
    input  logic         pop,
    input  logic [A-1:0] data_in,
    output logic [A-1:0] data_out,
    output logic         full,
    output logic         empty
);
    localparam int SPW = $clog2(S + 1);
    localparam int IW  = (S > 1) ? $clog2(S) : 1;

    logic [SPW-1:0] sp_reg;
    logic [A-1:0]   mem_reg [S];
    logic [S-1:0]   wr_en;
    logic [IW-1:0]  top_idx;

    assign full    = (sp_reg == SPW'(S));
    assign empty   = (sp_reg == '0);
    assign top_idx = IW'(sp_reg - SPW'(1));

    // One write strobe per entry: the slot addressed by sp is the next free one
    genvar gi;
    generate
        for (gi = 0; gi < S; gi++) begin : g_wr
            assign wr_en[gi] = push && !full && (sp_reg == SPW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < S; i++) mem_reg[i] <= '0;
        end else begin
            for (int i = 0; i < S; i++) begin
                if (wr_en[i]) mem_reg[i] <= data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)               sp_reg <= '0;
        else if (push && !full)    sp_reg <= sp_reg + SPW'(1);
        else if (pop && !empty)    sp_reg <= sp_reg - SPW'(1);
    end

    assign data_out = empty ? '0 : mem_reg[top_idx];
endmodule

// File: rtl/pico_pc_seq.sv
// PicoMIPS program-counter sequencer: applies modePC each RUN cycle, owns the
// return stack, and implements HALT / WFI run control.
module pico_pc_seq
    import pico_pc_seq_pkg::*;
(
    input logic          clk,
    input logic          nReset,
    pico_pc_seq_if.slave bus
);
    pc_state_t    state_reg, state_next;
    logic [A-1:0] pc_reg, pc_next;
    logic         ovf_reg, ovf_next;
    logic         unf_reg, unf_next;
    logic         push, pop, stk_full, stk_empty;
    logic [A-1:0] stk_top;
    logic [A-1:0] pc_inc;
    logic [W_IMM:0] rel_sum;

    assign pc_inc  = pc_reg + A'(1);
    assign rel_sum = (W_IMM + 1)'(pc_reg) + sext_imm(bus.imm);

    pico_ret_stack #(.A(A), .S(S)) u_stk (
        .clk      (clk),
        .nReset   (nReset),
        .push     (push),
        .pop      (pop),
        .data_in  (pc_inc),
        .data_out (stk_top),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_reg <= RUN;
            pc_reg    <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        push       = 1'b0;
        pop        = 1'b0;
        case (state_reg)
            RUN: begin
                if (bus.halt_req) begin
                    state_next = HALT;
                end else if (bus.wfi_req) begin
                    state_next = WAIT;
                end else begin
                    case (bus.mode)
                        INCREMENT: pc_next = pc_inc;
                        RELATIVE:  pc_next = bus.branch_take ? rel_sum[A-1:0] : pc_inc;
                        SUBROUTINE: begin
                            if (!stk_full) begin
                                push    = 1'b1;
                                pc_next = bus.imm[A-1:0];
                            end else begin
                                ovf_next   = 1'b1;
                                state_next = HALT;
                            end
                        end
                        RETURN: begin
                            if (!stk_empty) begin
                                pop     = 1'b1;
                                pc_next = stk_top;
                            end else begin
                                unf_next   = 1'b1;
                                state_next = HALT;
                            end
                        end
                        default: pc_next = pc_inc;
                    endcase
                end
            end
            // irq is only looked at once WAIT is already the registered state
            WAIT: begin
                if (bus.irq) begin
                    pc_next    = pc_inc;
                    state_next = RUN;
                end
            end
            default: ;
        endcase
    end

    assign bus.pc      = pc_reg;
    assign bus.running = (state_reg == RUN);
    assign bus.waiting = (state_reg == WAIT);
    assign bus.stk_ovf = ovf_reg;
    assign bus.stk_unf = unf_reg;
endmodule

// File: tb/tb_pico_pc_seq.sv
// Scoreboard bench for pico_pc_seq: stimulus queues expected post-edge state,
// a monitor pops and compares one transaction per clock.
module tb_pico_pc_seq;
    import pico_pc_seq_pkg::*;

    typedef struct {
        logic [3:0] pc;
        logic       run;
        logic       wt;
        logic       ovf;
        logic       unf;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    pico_pc_seq_if bus();

    pico_pc_seq dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_state(input string nm, input logic [3:0] epc, input logic erun,
                               input logic ewt, input logic eovf, input logic eunf);
        checks++;
        if (bus.pc !== epc || bus.running !== erun || bus.waiting !== ewt ||
            bus.stk_ovf !== eovf || bus.stk_unf !== eunf) begin
            errors++;
            $display("FAIL %s: got pc=%0d run=%b wait=%b ovf=%b unf=%b, expected pc=%0d run=%b wait=%b ovf=%b unf=%b",
                     nm, bus.pc, bus.running, bus.waiting, bus.stk_ovf, bus.stk_unf,
                     epc, erun, ewt, eovf, eunf);
        end else begin
            $display("ok   %s: pc=%0d run=%b wait=%b ovf=%b unf=%b",
                     nm, bus.pc, bus.running, bus.waiting, bus.stk_ovf, bus.stk_unf);
        end
    endtask

    // Monitor: the DUT presents a new state every clock; compare whenever one is expected
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_state(e.name, e.pc, e.run, e.wt, e.ovf, e.unf);
            end
        end
    end

    // Drive one cycle of decoder inputs (called on a falling edge) and queue the result
    task automatic step(input mode_pc_t m, input logic [7:0] im, input logic tk,
                        input logic hr, input logic wr, input logic iq,
                        input logic [3:0] epc, input logic erun, input logic ewt,
                        input logic eovf, input logic eunf, input string nm);
        exp_t e;
        bus.mode        = m;
        bus.imm         = im;
        bus.branch_take = tk;
        bus.halt_req    = hr;
        bus.wfi_req     = wr;
        bus.irq         = iq;
        e.pc = epc; e.run = erun; e.wt = ewt; e.ovf = eovf; e.unf = eunf; e.name = nm;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.mode = INCREMENT; bus.imm = 8'h00; bus.branch_take = 1'b0;
        bus.halt_req = 1'b0; bus.wfi_req = 1'b0; bus.irq = 1'b0;
    endtask

    // Async reset pulse: outputs must clear before any clock edge
    task automatic reset_pulse(input string nm);
        nReset = 1'b0;
        #1;
        check_state(nm, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_inputs();
        @(negedge clk);
        nReset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        #2;
        check_state("reset_state", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        nReset = 1'b1;

        // 1: increment with wrap
        for (int i = 0; i < 18; i++)
            step(INCREMENT, 8'h00, 0, 0, 0, 0, 4'((i + 1) % 16), 1, 0, 0, 0, "inc_wrap");

        // 2: relative branches (pc=2 here)
        for (int i = 0; i < 3; i++) step(INCREMENT, 8'h00, 0, 0, 0, 0, 4'(3 + i), 1, 0, 0, 0, "inc_to5");
        step(RELATIVE, 8'hFD, 1, 0, 0, 0, 4'd2, 1, 0, 0, 0, "rel_back3");
        for (int i = 0; i < 3; i++) step(INCREMENT, 8'h00, 0, 0, 0, 0, 4'(3 + i), 1, 0, 0, 0, "inc_to5b");
        step(RELATIVE, 8'hFD, 0, 0, 0, 0, 4'd6, 1, 0, 0, 0, "rel_not_taken");
        for (int i = 0; i < 8; i++) step(INCREMENT, 8'h00, 0, 0, 0, 0, 4'(7 + i), 1, 0, 0, 0, "inc_to14");
        step(RELATIVE, 8'h03, 1, 0, 0, 0, 4'd1, 1, 0, 0, 0, "rel_fwd_wrap");

        // 3: call / return
        step(INCREMENT,  8'h00, 0, 0, 0, 0, 4'd2,  1, 0, 0, 0, "inc_to2");
        step(SUBROUTINE, 8'h09, 0, 0, 0, 0, 4'd9,  1, 0, 0, 0, "jsbr_9");
        step(INCREMENT,  8'h00, 0, 0, 0, 0, 4'd10, 1, 0, 0, 0, "sub_inc1");
        step(INCREMENT,  8'h00, 0, 0, 0, 0, 4'd11, 1, 0, 0, 0, "sub_inc2");
        step(RETURN,     8'h00, 0, 0, 0, 0, 4'd3,  1, 0, 0, 0, "rsbr_to3");

        // 5: WFI with irq on the entry cycle ignored, halt_req/mode ignored while waiting
        step(INCREMENT,  8'h00, 0, 0, 0, 0, 4'd4, 1, 0, 0, 0, "inc_to4");
        step(INCREMENT,  8'h00, 0, 0, 1, 1, 4'd4, 0, 1, 0, 0, "wfi_enter");
        step(INCREMENT,  8'h00, 0, 0, 0, 0, 4'd4, 0, 1, 0, 0, "wait_hold1");
        step(RETURN,     8'h00, 0, 1, 0, 0, 4'd4, 0, 1, 0, 0, "wait_hold2");
        step(SUBROUTINE, 8'h07, 0, 0, 1, 0, 4'd4, 0, 1, 0, 0, "wait_hold3");
        step(INCREMENT,  8'h00, 0, 0, 0, 1, 4'd5, 1, 0, 0, 0, "wait_irq");

        // Stack should be empty again: RETURN underflows and halts
        step(RETURN,     8'h00, 0, 0, 0, 0, 4'd5, 0, 0, 0, 1, "rsbr_empty");
        step(INCREMENT,  8'h00, 0, 0, 0, 0, 4'd5, 0, 0, 0, 1, "halt_frozen");
        step(SUBROUTINE, 8'h02, 0, 0, 0, 1, 4'd5, 0, 0, 0, 1, "halt_frozen2");
        reset_pulse("reset_mid_halt");

        // LIFO order including a wrapped push (pc 15 -> return address 0)
        step(SUBROUTINE, 8'h08, 0, 0, 0, 0, 4'd8,  1, 0, 0, 0, "nest_call1");
        step(SUBROUTINE, 8'h0C, 0, 0, 0, 0, 4'd12, 1, 0, 0, 0, "nest_call2");
        step(SUBROUTINE, 8'h0F, 0, 0, 0, 0, 4'd15, 1, 0, 0, 0, "nest_call3");
        step(SUBROUTINE, 8'h04, 0, 0, 0, 0, 4'd4,  1, 0, 0, 0, "nest_call4");
        step(RETURN,     8'h00, 0, 0, 0, 0, 4'd0,  1, 0, 0, 0, "nest_ret4");
        step(RETURN,     8'h00, 0, 0, 0, 0, 4'd13, 1, 0, 0, 0, "nest_ret3");
        step(RETURN,     8'h00, 0, 0, 0, 0, 4'd9,  1, 0, 0, 0, "nest_ret2");
        step(RETURN,     8'h00, 0, 0, 0, 0, 4'd1,  1, 0, 0, 0, "nest_ret1");
        reset_pulse("reset_after_nest");

        // 4: overflow on the fifth nested call
        step(SUBROUTINE, 8'h01, 0, 0, 0, 0, 4'd1, 1, 0, 0, 0, "ovf_call1");
        step(SUBROUTINE, 8'h02, 0, 0, 0, 0, 4'd2, 1, 0, 0, 0, "ovf_call2");
        step(SUBROUTINE, 8'h03, 0, 0, 0, 0, 4'd3, 1, 0, 0, 0, "ovf_call3");
        step(SUBROUTINE, 8'h04, 0, 0, 0, 0, 4'd4, 1, 0, 0, 0, "ovf_call4");
        step(SUBROUTINE, 8'h05, 0, 0, 0, 0, 4'd4, 0, 0, 1, 0, "ovf_call5");
        step(RETURN,     8'h00, 0, 0, 0, 0, 4'd4, 0, 0, 1, 0, "ovf_frozen");
        reset_pulse("reset_after_ovf");
        step(RETURN,     8'h00, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1, "unf_fresh");
        reset_pulse("reset_after_unf");

        // 6: reset mid-WAIT, then halt beats wfi in the same cycle
        step(INCREMENT,  8'h00, 0, 0, 0, 0, 4'd1, 1, 0, 0, 0, "pre_wait_inc");
        step(INCREMENT,  8'h00, 0, 0, 1, 0, 4'd1, 0, 1, 0, 0, "wfi_enter2");
        reset_pulse("reset_mid_wait");
        step(INCREMENT,  8'h00, 0, 1, 1, 0, 4'd0, 0, 0, 0, 0, "halt_over_wfi");
        step(INCREMENT,  8'h00, 0, 0, 0, 1, 4'd0, 0, 0, 0, 0, "halt_ignores_irq");

        idle_inputs();
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
